// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC/IR registers plus a one-entry prefetch buffer driving imem req/ack.
// Optional ack timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module fetch_pc_unit #(
    parameter int unsigned        DATA_W         = 16,
    parameter int unsigned        ADDR_W         = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC       = 16'h0000,
    parameter int unsigned        TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        PCSrc,
    input  logic              PCWrite,
    input  logic              PCBEqCond,
    input  logic              PCBNqCond,
    input  logic              IRWrite,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [3:0]        func_field,
    output logic              ibuf_valid,
    output logic              fetch_stall,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_LAUNCH = 2'd0,
        S_REQ    = 2'd1,
        S_DROP   = 2'd2,
        S_FULL   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_target_c;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ibuf_q, ibuf_d;
    logic              cond_c, pc_load_c, flush_c, timeout_c;

    // PC control decode; a stalled fetch step must not move the PC.
    assign fetch_stall = IRWrite & (state_q != S_FULL);
    assign cond_c      = PCWrite | (PCBEqCond & alu_zero) | (PCBNqCond & ~alu_zero);
    assign pc_load_c   = ~fetch_stall & cond_c & (PCSrc != 2'b11);
    assign flush_c     = pc_load_c & ~IRWrite;

    always_comb begin
        pc_target_c = pc_q;
        case (PCSrc)
            2'b00:   pc_target_c = ADDR_W'(alu_result);
            2'b01:   pc_target_c = ADDR_W'(alu_out);
            2'b10:   pc_target_c = {pc_q[ADDR_W-1:ADDR_W-4], ir_q[ADDR_W-5:0]};
            default: pc_target_c = pc_q;
        endcase
    end

    assign pc_d = pc_load_c ? pc_target_c : pc_q;
    assign ir_d = (IRWrite && (state_q == S_FULL)) ? ibuf_q : ir_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout_c = ((state_q == S_REQ) || (state_q == S_DROP)) && !imem_ack
                       && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter restarts on every state change.
    always_comb begin
        cnt_d = '0;
        err_d = err_q | timeout_c;
        if (((state_q == S_REQ) || (state_q == S_DROP)) && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYCLES;

    assign timeout_c = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // Prefetch FSM next-state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ibuf_d  = ibuf_q;
        case (state_q)
            S_LAUNCH: begin
                addr_d = pc_q;
                if (!flush_c) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (flush_c) begin
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FULL;
                        ibuf_d  = imem_rdata;
                    end
                end else if (timeout_c) begin
                    state_d = S_LAUNCH;
                end else if (flush_c) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack || timeout_c) begin
                    state_d = S_LAUNCH;
                end
            end
            S_FULL: begin
                if (IRWrite || flush_c) begin
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_LAUNCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LAUNCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ir_q    <= '0;
            ibuf_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            ibuf_q  <= ibuf_d;
        end
    end

    assign imem_req   = (state_q == S_REQ) || (state_q == S_DROP);
    assign ibuf_valid = (state_q == S_FULL);
    assign imem_addr  = addr_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign opcode     = ir_q[DATA_W-1:DATA_W-4];
    assign func_field = ir_q[3:0];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: scoreboard of expected request addresses and IR loads.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSrc;
    logic        PCWrite, PCBEqCond, PCBNqCond, IRWrite, alu_zero, imem_ack;
    logic [15:0] alu_result, alu_out, imem_rdata;
    logic        imem_req, ibuf_valid, fetch_stall, fetch_err;
    logic [15:0] imem_addr, pc, ir;
    logic [3:0]  opcode, func_field;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_ir_q[$];

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .PCWrite(PCWrite), .PCBEqCond(PCBEqCond),
        .PCBNqCond(PCBNqCond), .IRWrite(IRWrite), .alu_result(alu_result), .alu_out(alu_out),
        .alu_zero(alu_zero), .imem_rdata(imem_rdata), .imem_ack(imem_ack), .imem_req(imem_req),
        .imem_addr(imem_addr), .pc(pc), .ir(ir), .opcode(opcode), .func_field(func_field),
        .ibuf_valid(ibuf_valid), .fetch_stall(fetch_stall), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        PCSrc = 2'b00; PCWrite = 0; PCBEqCond = 0; PCBNqCond = 0; IRWrite = 0;
        alu_zero = 0; imem_ack = 0;
    endtask

    // Bounded wait for imem_req; ok=0 if it never rises.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Wait for a request and compare its address with the scoreboard head.
    task automatic check_next_req(input string name);
        bit          ok;
        logic [15:0] e;
        wait_req(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: imem_req never rose within budget", name);
        end else begin
            e = exp_addr_q.pop_front();
            if (imem_addr !== e) begin
                errors++;
                $display("FAIL %s: imem_addr got %h expected %h", name, imem_addr, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ctrl();
        alu_result = '0; alu_out = '0; imem_rdata = '0;
        step(); step();
        checks++;
        if ({pc, ir, imem_addr} !== {16'h0000, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_regs: pc=%h ir=%h addr=%h expected 0000 0000 0000", pc, ir, imem_addr);
        end
        checks++;
        if ({imem_req, ibuf_valid, fetch_stall, fetch_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: req/valid/stall/err=%b expected 0000",
                     {imem_req, ibuf_valid, fetch_stall, fetch_err});
        end
    endtask

    task automatic test_first_fetch();
        rst = 1'b0;
        exp_addr_q.push_back(16'h0000);
        step();
        check_next_req("first_req_addr");
        imem_ack = 1; imem_rdata = 16'h8123;
        exp_ir_q.push_back(16'h8123);
        step();
        imem_ack = 0;
        checks++;
        if (ibuf_valid !== 1'b1 || pc !== 16'h0000) begin
            errors++;
            $display("FAIL first_fill: ibuf_valid=%b pc=%h expected 1 0000", ibuf_valid, pc);
        end
    endtask

    task automatic test_fetch_step();
        logic [15:0] e;
        IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 16'h0001;
        #1;
        checks++;
        if (fetch_stall !== 1'b0) begin
            errors++;
            $display("FAIL step_no_stall: fetch_stall=%b expected 0", fetch_stall);
        end
        step();
        clear_ctrl();
        e = exp_ir_q.pop_front();
        checks++;
        if (ir !== e || opcode !== e[15:12] || func_field !== e[3:0] || pc !== 16'h0001 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_step: ir=%h op=%h fn=%h pc=%h req=%b expected %h %h %h 0001 0",
                     ir, opcode, func_field, pc, imem_req, e, e[15:12], e[3:0]);
        end
        exp_addr_q.push_back(16'h0001);
        step();
        check_next_req("step_req_addr");
    endtask

    task automatic test_stall();
        int          stalls;
        bit          frozen;
        logic [15:0] e;
        stalls = 0; frozen = 1'b1;
        IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (fetch_stall === 1'b1) stalls++;
            if (pc !== 16'h0001 || ir !== 16'h8123) frozen = 1'b0;
            step();
        end
        checks++;
        if (stalls != 5 || !frozen) begin
            errors++;
            $display("FAIL stall_window: stalls=%0d frozen=%b expected 5 1", stalls, frozen);
        end
        imem_ack = 1; imem_rdata = 16'h1234;
        exp_ir_q.push_back(16'h1234);
        step();
        imem_ack = 0;
        #1;
        checks++;
        if (fetch_stall !== 1'b0 || pc !== 16'h0001) begin
            errors++;
            $display("FAIL stall_release: stall=%b pc=%h expected 0 0001", fetch_stall, pc);
        end
        step();
        clear_ctrl();
        e = exp_ir_q.pop_front();
        checks++;
        if (ir !== e || pc !== 16'h0002) begin
            errors++;
            $display("FAIL stall_load: ir=%h pc=%h expected %h 0002", ir, pc, e);
        end
        exp_addr_q.push_back(16'h0002);
        step();
        check_next_req("stall_next_addr");
    endtask

    task automatic test_branch();
        logic [15:0] e;
        PCBEqCond = 1; alu_zero = 1; PCSrc = 2'b01; alu_out = 16'h0040;
        step();
        clear_ctrl();
        checks++;
        if (pc !== 16'h0040 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL branch_drop: pc=%h req=%b addr=%h expected 0040 1 0002", pc, imem_req, imem_addr);
        end
        imem_ack = 1; imem_rdata = 16'hDEAD;
        step();
        imem_ack = 0;
        checks++;
        if (ibuf_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stale_drop: valid=%b req=%b expected 0 0", ibuf_valid, imem_req);
        end
        exp_addr_q.push_back(16'h0040);
        step();
        check_next_req("branch_target_addr");
        imem_ack = 1; imem_rdata = 16'h3ABC;
        exp_ir_q.push_back(16'h3ABC);
        step();
        imem_ack = 0;
        PCBEqCond = 1; alu_zero = 0; PCSrc = 2'b01; alu_out = 16'h0080;
        step();
        clear_ctrl();
        checks++;
        if (pc !== 16'h0040 || ibuf_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_not_taken: pc=%h valid=%b expected 0040 1", pc, ibuf_valid);
        end
        PCWrite = 1; PCSrc = 2'b11; alu_result = 16'h0999;
        step();
        clear_ctrl();
        checks++;
        if (pc !== 16'h0040 || ibuf_valid !== 1'b1) begin
            errors++;
            $display("FAIL pcsrc_hold: pc=%h valid=%b expected 0040 1", pc, ibuf_valid);
        end
        IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 16'h5002;
        step();
        clear_ctrl();
        e = exp_ir_q.pop_front();
        checks++;
        if (ir !== e || pc !== 16'h5002) begin
            errors++;
            $display("FAIL branch_load: ir=%h pc=%h expected %h 5002", ir, pc, e);
        end
        exp_addr_q.push_back(16'h5002);
        step();
        check_next_req("load_next_addr");
    endtask

    task automatic test_jump();
        logic [15:0] e_pc;
        imem_ack = 1; imem_rdata = 16'h1111;
        step();
        imem_ack = 0;
        e_pc = {pc[15:12], ir[11:0]};
        PCWrite = 1; PCSrc = 2'b10;
        step();
        clear_ctrl();
        checks++;
        if (pc !== 16'h5ABC || e_pc !== 16'h5ABC || ibuf_valid !== 1'b0 || ir !== 16'h3ABC) begin
            errors++;
            $display("FAIL jump: pc=%h valid=%b ir=%h expected 5ABC 0 3ABC", pc, ibuf_valid, ir);
        end
        exp_addr_q.push_back(16'h5ABC);
        step();
        check_next_req("jump_req_addr");
        // Redirect with ack in the same cycle drops the returned word.
        PCBNqCond = 1; alu_zero = 0; PCSrc = 2'b00; alu_result = 16'h0100;
        imem_ack = 1; imem_rdata = 16'hBEEF;
        step();
        clear_ctrl();
        checks++;
        if (pc !== 16'h0100 || ibuf_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bnq_ack_flush: pc=%h valid=%b req=%b expected 0100 0 0", pc, ibuf_valid, imem_req);
        end
        exp_addr_q.push_back(16'h0100);
        step();
        check_next_req("bnq_req_addr");
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst: req=%b pc=%h expected 0 0000", imem_req, pc);
        end
        step();
        imem_ack = 1; imem_rdata = 16'h7777;
        rst = 1'b0;
        exp_addr_q.push_back(16'h0000);
        step();
        imem_ack = 0;
        checks++;
        if (ibuf_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL late_ack: valid=%b req=%b expected 0 1", ibuf_valid, imem_req);
        end
        check_next_req("post_rst_addr");
    endtask

    task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
        int n;
        n = 0;
        while (fetch_err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 16 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: cycles=%0d req=%b expected 16 0", n, imem_req);
        end
        exp_addr_q.push_back(16'h0000);
        step();
        check_next_req("timeout_retry_addr");
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: fetch_err=%b expected 1", fetch_err);
        end
`else
        repeat (20) step();
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL no_timeout: err=%b req=%b addr=%h expected 0 1 0000", fetch_err, imem_req, imem_addr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_fetch_step();
        test_stall();
        test_branch();
        test_jump();
        test_async_reset();
        test_timeout();
        checks++;
        if (exp_addr_q.size() != 0 || exp_ir_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: addr_left=%0d ir_left=%0d expected 0 0",
                     exp_addr_q.size(), exp_ir_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
